// File: rtl/mem_ctrl_rr.sv
// Byte-serial RAM/IO controller serving NUM_PORTS word requesters with round-robin arbitration.
// Optional feature macro UART_HOLD_EN: stall IO-space write bytes while uart_full is set.
module mem_ctrl_rr #(
    parameter int unsigned       NUM_PORTS = 2,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       RAM_LAT   = 1,
    parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(32'h30000)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [7:0]              ram_din,
    input  logic                    uart_full,
    output logic                    ram_wr,
    output logic [7:0]              ram_dout,
    output logic [ADDR_W-1:0]       ram_addr,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [2*NUM_PORTS-1:0]  size_i,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr_i,
    input  logic [32*NUM_PORTS-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    done_o,
    output logic [31:0]             rdata_o
);

    localparam int unsigned PW   = $clog2(NUM_PORTS);
    localparam logic [2:0]  LAT3 = 3'(RAM_LAT);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state, state_n;
    logic [PW-1:0]         rr_ptr, rr_ptr_n, gnt, gnt_n, arb;
    logic                  arb_ok;
    logic [ADDR_W-1:0]     base, base_n, ram_addr_n, target;
    logic [2:0]            nbytes, nbytes_n, cnt, cnt_n, widx;
    logic [31:0]           rbuf, rbuf_n, rdata_n, din_sh, wd;
    logic [PW-1:0]         wsel;
    logic                  ram_wr_n, hold;
    logic [7:0]            ram_dout_n;
    logic [NUM_PORTS-1:0]  done_n;

    logic [ADDR_W-1:0]     addr_a  [NUM_PORTS];
    logic [31:0]           wdata_a [NUM_PORTS];
    logic [1:0]            size_a  [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_a[p]  = addr_i[p*ADDR_W +: ADDR_W];
        assign wdata_a[p] = wdata_i[p*32 +: 32];
        assign size_a[p]  = size_i[p*2 +: 2];
    end

    function automatic logic [2:0] bytes_of(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Round-robin: scan rr_ptr+1, rr_ptr+2, ... so the last-served port comes last.
    always_comb begin
        int unsigned idx;
        arb    = '0;
        arb_ok = 1'b0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_PORTS;
            if (!arb_ok && req_i[idx]) begin
                arb    = PW'(idx);
                arb_ok = 1'b1;
            end
        end
    end

    assign target = (state == IDLE) ? addr_a[arb] : base + ADDR_W'(cnt);
    assign wsel   = (state == IDLE) ? arb : gnt;
    assign widx   = (state == IDLE) ? 3'd0 : cnt;
    assign wd     = wdata_a[wsel] >> {widx, 3'b000};
    assign din_sh = {24'b0, ram_din} << {cnt - LAT3, 3'b000};

`ifdef UART_HOLD_EN
    assign hold = uart_full && (target >= IO_BASE);
`else
    logic unused_hold;
    assign hold        = 1'b0;
    assign unused_hold = uart_full | (target >= IO_BASE);
`endif

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        gnt_n      = gnt;
        base_n     = base;
        nbytes_n   = nbytes;
        cnt_n      = cnt;
        rbuf_n     = rbuf;
        ram_wr_n   = ram_wr;
        ram_dout_n = ram_dout;
        ram_addr_n = ram_addr;
        done_n     = '0;
        rdata_n    = rdata_o;
        unique case (state)
            IDLE: begin
                ram_wr_n = 1'b0;
                if (arb_ok) begin
                    rr_ptr_n   = arb;
                    gnt_n      = arb;
                    base_n     = addr_a[arb];
                    nbytes_n   = bytes_of(size_a[arb]);
                    ram_addr_n = addr_a[arb];
                    rbuf_n     = '0;
                    cnt_n      = 3'd1;
                    if (we_i[arb]) begin
                        state_n = WRITE;
                        if (hold) begin
                            cnt_n = 3'd0;
                        end else begin
                            ram_wr_n   = 1'b1;
                            ram_dout_n = wd[7:0];
                        end
                    end else begin
                        state_n = READ;
                    end
                end
            end
            // READ: cnt counts edges since grant; byte (cnt-RAM_LAT) is on ram_din now.
            READ: begin
                if (!req_i[gnt]) begin
                    state_n  = IDLE;
                    ram_wr_n = 1'b0;
                end else begin
                    if (cnt < nbytes) ram_addr_n = base + ADDR_W'(cnt);
                    if (cnt >= LAT3) rbuf_n = rbuf | din_sh;
                    if (cnt == nbytes - 3'd1 + LAT3) begin
                        state_n = IDLE;
                        done_n  = NUM_PORTS'(1) << gnt;
                        rdata_n = rbuf | din_sh;
                    end
                    cnt_n = cnt + 3'd1;
                end
            end
            // WRITE: cnt is the index of the next byte to issue.
            WRITE: begin
                if (!req_i[gnt]) begin
                    state_n  = IDLE;
                    ram_wr_n = 1'b0;
                end else if (cnt == nbytes) begin
                    state_n  = IDLE;
                    ram_wr_n = 1'b0;
                    done_n   = NUM_PORTS'(1) << gnt;
                end else if (hold) begin
                    ram_wr_n = 1'b0;
                end else begin
                    ram_wr_n   = 1'b1;
                    ram_addr_n = target;
                    ram_dout_n = wd[7:0];
                    cnt_n      = cnt + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= PW'(NUM_PORTS - 1);
            gnt      <= '0;
            base     <= '0;
            nbytes   <= '0;
            cnt      <= '0;
            rbuf     <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
            ram_addr <= '0;
            done_o   <= '0;
            rdata_o  <= '0;
        end else if (rdy) begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            gnt      <= gnt_n;
            base     <= base_n;
            nbytes   <= nbytes_n;
            cnt      <= cnt_n;
            rbuf     <= rbuf_n;
            ram_wr   <= ram_wr_n;
            ram_dout <= ram_dout_n;
            ram_addr <= ram_addr_n;
            done_o   <= done_n;
            rdata_o  <= rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_rr.sv
// Bench for mem_ctrl_rr: transaction-level reference model plus directed literal checks and random traffic.
module tb_mem_ctrl_rr;
    localparam int          NP  = 2;
    localparam int          AW  = 32;
    localparam int          LAT = 1;
    localparam logic [31:0] IOB = 32'h30000;

    logic              clk = 1'b0, rst = 1'b0, rdy = 1'b0, uart_full = 1'b0;
    logic [7:0]        ram_din, ram_dout;
    logic              ram_wr;
    logic [AW-1:0]     ram_addr;
    logic [NP-1:0]     req_i = '0, we_i = '0, done_o;
    logic [2*NP-1:0]   size_i = '0;
    logic [AW*NP-1:0]  addr_i = '0;
    logic [32*NP-1:0]  wdata_i = '0;
    logic [31:0]       rdata_o;

    mem_ctrl_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .RAM_LAT(LAT), .IO_BASE(IOB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ram_din(ram_din), .uart_full(uart_full),
        .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_addr(ram_addr),
        .req_i(req_i), .we_i(we_i), .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .done_o(done_o), .rdata_o(rdata_o)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem   [1024];
    logic [7:0] model_mem [1024];
    assign ram_din = ram_mem[ram_addr[9:0]];

    initial forever begin
        @(posedge clk);
        if (ram_wr) ram_mem[ram_addr[9:0]] = ram_dout;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected bus/handshake state, derived per transaction step.
    logic          e_wr = 1'b0, e_addr_ok = 1'b1;
    logic [7:0]    e_dout = '0;
    logic [31:0]   e_addr = '0, e_rdata = '0, m_base = '0;
    logic [NP-1:0] e_done = '0;
    bit            m_busy = 1'b0, m_we = 1'b0;
    int            m_ptr = NP - 1, m_g = 0, m_n = 1, m_j = 0, m_cnt = 0;

    task automatic m_issue();
        logic [31:0] t;
        bit          hold;
        t    = m_base + 32'(m_cnt);
        hold = 1'b0;
`ifdef UART_HOLD_EN
        hold = (t >= IOB) && uart_full;
`endif
        if (hold) begin
            e_wr = 1'b0; e_addr_ok = 1'b0;
        end else begin
            e_wr = 1'b1; e_addr = t; e_addr_ok = 1'b1;
            e_dout = wdata_i[m_g*32 + m_cnt*8 +: 8];
            m_cnt++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (rst && e_wr) model_mem[e_addr[9:0]] = e_dout;
        if (!rst) begin
            m_busy = 1'b0; m_ptr = NP - 1; e_wr = 1'b0; e_dout = '0;
            e_addr = '0; e_addr_ok = 1'b1; e_done = '0; e_rdata = '0;
        end else if (rdy) begin
            e_done = '0;
            if (m_busy) begin
                m_j++;
                if (!req_i[m_g]) begin
                    m_busy = 1'b0; e_wr = 1'b0; e_addr_ok = 1'b0;
                end else if (!m_we) begin
                    e_addr_ok = (m_j < m_n);
                    if (m_j < m_n) e_addr = m_base + 32'(m_j);
                    if (m_j == m_n - 1 + LAT) begin
                        e_rdata = '0;
                        for (int k = 0; k < m_n; k++)
                            e_rdata[8*k +: 8] = model_mem[10'(m_base + 32'(k))];
                        e_done[m_g] = 1'b1;
                        m_busy = 1'b0;
                    end
                end else if (m_cnt == m_n) begin
                    e_wr = 1'b0; e_addr_ok = 1'b0; e_done[m_g] = 1'b1; m_busy = 1'b0;
                end else begin
                    m_issue();
                end
            end else begin
                int g;
                g = -1;
                for (int i = 1; i <= NP; i++)
                    if (g < 0 && req_i[(m_ptr + i) % NP]) g = (m_ptr + i) % NP;
                if (g < 0) begin
                    e_wr = 1'b0; e_addr_ok = 1'b0;
                end else begin
                    m_busy = 1'b1; m_ptr = g; m_g = g; m_we = we_i[g];
                    m_base = addr_i[g*AW +: AW];
                    case (size_i[2*g +: 2])
                        2'd0:    m_n = 1;
                        2'd1:    m_n = 2;
                        default: m_n = 4;
                    endcase
                    m_j = 0; m_cnt = 0;
                    if (m_we) m_issue();
                    else begin
                        e_wr = 1'b0; e_addr = m_base; e_addr_ok = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        check("ram_wr", 32'(ram_wr), 32'(e_wr));
        check("done_o", 32'(done_o), 32'(e_done));
        check("rdata_o", rdata_o, e_rdata);
        if (e_addr_ok) check("ram_addr", ram_addr, e_addr);
        if (e_wr) check("ram_dout", 32'(ram_dout), 32'(e_dout));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram_mem[a[9:0]] = d;
        model_mem[a[9:0]] = d;
    endtask

    task automatic set_req(input int p, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        we_i[p] = we;
        size_i[2*p +: 2] = sz;
        addr_i[p*AW +: AW] = a;
        wdata_i[p*32 +: 32] = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, 1023));
            2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: return IOB + 32'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = 8'($urandom);
            model_mem[i] = ram_mem[i];
        end
        repeat (3) step();
        check("rst_addr", ram_addr, 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        rst = 1'b1; rdy = 1'b1;
        step();

        // Word read from port 1
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        set_req(1, 1'b0, 2'd2, 32'h100, 32'h0);
        req_i = 2'b10;
        repeat (4) step();
        check("t1_early_done", 32'(done_o), 32'h0);
        step();
        check("t1_done", 32'(done_o), 32'h2);
        check("t1_rdata", rdata_o, 32'h4433_2211);
        req_i = '0;

        // Simultaneous requests: port 0 first, port 1 right after
        poke(32'h10, 8'hA5); poke(32'h20, 8'h3C);
        set_req(0, 1'b0, 2'd0, 32'h10, 32'h0);
        set_req(1, 1'b0, 2'd0, 32'h20, 32'h0);
        req_i = 2'b11;
        step(); check("t2_addr0", ram_addr, 32'h10);
        step(); check("t2_done0", 32'(done_o), 32'h1); check("t2_rdata0", rdata_o, 32'hA5);
        req_i[0] = 1'b0;
        step(); check("t2_addr1", ram_addr, 32'h20);
        step(); check("t2_done1", 32'(done_o), 32'h2); check("t2_rdata1", rdata_o, 32'h3C);
        req_i = '0;

        // Half write from port 1
        set_req(1, 1'b1, 2'd1, 32'h2000, 32'h0000_BEEF);
        req_i = 2'b10;
        step(); check("t3_wr0", 32'(ram_wr), 1); check("t3_a0", ram_addr, 32'h2000); check("t3_d0", 32'(ram_dout), 32'hEF);
        step(); check("t3_wr1", 32'(ram_wr), 1); check("t3_a1", ram_addr, 32'h2001); check("t3_d1", 32'(ram_dout), 32'hBE);
        step(); check("t3_wr2", 32'(ram_wr), 0); check("t3_done", 32'(done_o), 32'h2);
        check("t3_mem0", 32'(ram_mem[0]), 32'hEF); check("t3_mem1", 32'(ram_mem[1]), 32'hBE);
        req_i = '0;

        // Abort of port 0 read, port 1 pending
        poke(32'h30, 8'h5A);
        set_req(0, 1'b0, 2'd2, 32'h200, 32'h0);
        set_req(1, 1'b0, 2'd0, 32'h30, 32'h0);
        req_i = 2'b11;
        step(); check("t4_a0", ram_addr, 32'h200);
        step(); check("t4_a1", ram_addr, 32'h201);
        req_i[0] = 1'b0;
        step(); check("t4_abort_wr", 32'(ram_wr), 0); check("t4_abort_done", 32'(done_o), 0);
        step(); check("t4_p1_addr", ram_addr, 32'h30);
        step(); check("t4_p1_done", 32'(done_o), 32'h2); check("t4_p1_rdata", rdata_o, 32'h5A);
        req_i = '0;

        // Address wrap on a word write
        set_req(0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'h0102_0304);
        req_i = 2'b01;
        step(); check("wrap_a0", ram_addr, 32'hFFFF_FFFE);
        step();
        step(); check("wrap_a2", ram_addr, 32'h0); check("wrap_d2", 32'(ram_dout), 32'h02);
        step();
        step(); check("wrap_done", 32'(done_o), 32'h1);
        req_i = '0;

`ifdef UART_HOLD_EN
        uart_full = 1'b1;
        set_req(0, 1'b1, 2'd0, IOB, 32'h66);
        req_i = 2'b01;
        repeat (3) begin step(); check("t5_hold", 32'(ram_wr), 0); end
        uart_full = 1'b0;
        step(); check("t5_wr", 32'(ram_wr), 1); check("t5_addr", ram_addr, IOB); check("t5_d", 32'(ram_dout), 32'h66);
        step(); check("t5_done", 32'(done_o), 32'h1);
        req_i = '0;
`endif

        // Reset in the middle of a word write
        poke(32'h41, 8'h77);
        set_req(0, 1'b1, 2'd2, 32'h40, 32'hA1B2_C3D4);
        req_i = 2'b01;
        step(); step();
        check("t6_a1", ram_addr, 32'h41);
        rst = 1'b0; #1;
        check("t6_rst_wr", 32'(ram_wr), 0); check("t6_rst_addr", ram_addr, 0);
        check("t6_rst_dout", 32'(ram_dout), 0); check("t6_rst_done", 32'(done_o), 0);
        check("t6_rst_rdata", rdata_o, 0);
        req_i = '0;
        step(); step();
        rst = 1'b1;
        check("t6_mem40", 32'(ram_mem[10'h40]), 32'hD4);
        check("t6_mem41", 32'(ram_mem[10'h41]), 32'h77);

        // rdy low for two cycles during a word read
        set_req(1, 1'b0, 2'd2, 32'h100, 32'h0);
        req_i = 2'b10;
        step(); step();
        rdy = 1'b0;
        step(); check("t6b_frozen_addr", ram_addr, 32'h101);
        step();
        rdy = 1'b1;
        step(); step(); check("t6b_early", 32'(done_o), 0);
        step(); check("t6b_done", 32'(done_o), 32'h2); check("t6b_rdata", rdata_o, 32'h4433_2211);
        req_i = '0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 7) != 0);
            uart_full = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < NP; p++) begin
                if (req_i[p] && done_o[p]) req_i[p] = 1'b0;
                else if (req_i[p] && $urandom_range(0, 49) == 0) req_i[p] = 1'b0;
                else if (!req_i[p] && $urandom_range(0, 2) == 0) begin
                    set_req(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), $urandom);
                    req_i[p] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) wdata_i[p*32 +: 32] = $urandom;
                if ($urandom_range(0, 5) == 0) begin
                    we_i[p] = 1'($urandom_range(0, 1));
                    size_i[2*p +: 2] = 2'($urandom_range(0, 3));
                    addr_i[p*AW +: AW] = rand_addr();
                end
            end
            step();
        end
        req_i = '0; rdy = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
